barrier_query_arbiter: RTL

- Shares one `rooms` barrier-lookup instance among NUM_REQ requesters (enemies, Mario, Luigi probes), replacing one lookup per probe point.
- Round-robin arbitration with valid/ready request handshake, a registered lookup address and a fixed-latency tagged response pipeline.
- Sits between the character/enemy movement logic and a single `rooms` instance; clocked on the pixel-domain clock.

---
 rtl/barrier_query_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/barrier_query_arbiter.sv
// Round-robin arbiter sharing one `rooms` barrier lookup among NUM_REQ requesters.
// Optional grant counter enabled by defining BQA_GRANT_STATS_EN.
module barrier_query_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int LOOKUP_LAT = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [10*NUM_REQ-1:0]   req_x,
  input  logic [10*NUM_REQ-1:0]   req_y,
  input  logic [2*NUM_REQ-1:0]    req_level,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic                    resp_barrier,
  output logic [9:0]              lk_x,
  output logic [9:0]              lk_y,
  output logic [1:0]              lk_level,
  input  logic                    lk_is_barrier,
`ifdef BQA_GRANT_STATS_EN
  input  logic                    frame_start,
  output logic [15:0]             grant_count,
`endif
  output logic                    busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a request transfers in any cycle where req_valid[i] & req_ready[i];
  // req_ready is one-hot, combinational, and only ever set on a valid requester.
  logic [PW-1:0] ptr;
  logic          grant_any;
  logic [PW-1:0] grant_idx;
  logic [9:0]    sel_x;
  logic [9:0]    sel_y;
  logic [1:0]    sel_level;

  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    if (!hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (int'(ptr) + k) % NUM_REQ;
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = PW'(cand);
        end
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_level = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_x     = req_x[10*i +: 10];
        sel_y     = req_y[10*i +: 10];
        sel_level = req_level[2*i +: 2];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr      <= '0;
      lk_x     <= '0;
      lk_y     <= '0;
      lk_level <= '0;
    end else if (grant_any) begin
      ptr      <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
      lk_x     <= sel_x;
      lk_y     <= sel_y;
      lk_level <= sel_level;
    end
  end

  // Tag stage s describes the lookup driven on lk_* during cycle grant+1+s.
  logic [LOOKUP_LAT-1:0] tag_v;
  logic [PW-1:0]         tag_idx [LOOKUP_LAT];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= grant_any;
      for (int s = 1; s < LOOKUP_LAT; s++) tag_v[s] <= tag_v[s-1];
    end
  end

  always_ff @(posedge Clk) begin
    tag_idx[0] <= grant_idx;
    for (int s = 1; s < LOOKUP_LAT; s++) tag_idx[s] <= tag_idx[s-1];
  end

  logic [NUM_REQ-1:0] resp_onehot;

  always_comb begin
    resp_onehot = '0;
    if (tag_v[LOOKUP_LAT-1]) resp_onehot[tag_idx[LOOKUP_LAT-1]] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      resp_valid   <= '0;
      resp_barrier <= 1'b0;
    end else begin
      resp_valid   <= resp_onehot;
      resp_barrier <= tag_v[LOOKUP_LAT-1] & lk_is_barrier;
    end
  end

  assign busy = |tag_v;

`ifdef BQA_GRANT_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant_count <= '0;
    end else if (frame_start) begin
      grant_count <= {15'd0, grant_any};
    end else if (grant_any && grant_count != 16'hFFFF) begin
      grant_count <= grant_count + 16'd1;
    end
  end
`endif

endmodule
